// File: rtl/mitchell_log_encoder.sv
// Two-stage Mitchell log encoder: leading-one detect, then fraction extract and packing as {k, frac}.
// Optional saturating fraction bias is enabled by defining BIAS_COMP_EN.
module mitchell_log_encoder #(
    parameter int               IN_W   = 16,
    parameter int               K_W    = 4,
    parameter int               FRAC_W = 7,
    parameter logic [FRAC_W-1:0] BIAS  = 7'd5,
    localparam int              LOG_W  = K_W + FRAC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOG_W-1:0] log_a,
    output logic [LOG_W-1:0] log_b,
    output logic             zero
);

`ifdef BIAS_COMP_EN
    localparam bit BIAS_ON = 1'b1;
`else
    localparam bit BIAS_ON = 1'b0;
`endif

    localparam logic [FRAC_W-1:0] BIAS_APPLIED = BIAS_ON ? BIAS : {FRAC_W{1'b0}};
    localparam int                SH           = IN_W - 1 - FRAC_W;

    function automatic logic [K_W-1:0] lead_one(input logic [IN_W-1:0] op);
        logic [K_W-1:0] k;
        k = {K_W{1'b0}};
        for (int i = 0; i < IN_W; i++) begin
            if (op[i]) k = K_W'(i);
        end
        return k;
    endfunction

    // Shift the leading one to the MSB, then keep the FRAC_W bits just below it.
    function automatic logic [FRAC_W-1:0] frac_of(input logic [IN_W-1:0] op, input logic [K_W-1:0] k);
        logic [IN_W-1:0] aligned;
        aligned = op << (K_W'(IN_W - 1) - k);
        return FRAC_W'(aligned >> SH);
    endfunction

    function automatic logic [FRAC_W-1:0] bias_sat(input logic [FRAC_W-1:0] f);
        logic [FRAC_W:0] sum;
        sum = {1'b0, f} + {1'b0, BIAS_APPLIED};
        return sum[FRAC_W] ? {FRAC_W{1'b1}} : sum[FRAC_W-1:0];
    endfunction

    function automatic logic [LOG_W-1:0] pack_log(input logic [IN_W-1:0] op, input logic [K_W-1:0] k);
        logic [LOG_W-1:0] r;
        if (op == {IN_W{1'b0}}) begin
            r = {LOG_W{1'b0}};
        end else begin
            r = {k, bias_sat(frac_of(op, k))};
        end
        return r;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [IN_W-1:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [K_W-1:0]   s1_ka_q, s1_ka_d, s1_kb_q, s1_kb_d;
    logic             s1_zero_q, s1_zero_d;
    logic             out_valid_q, out_valid_d;
    logic [LOG_W-1:0] log_a_q, log_a_d, log_b_q, log_b_d;
    logic             zero_q, zero_d;
    logic             s1_load_s, s2_load_s;

    // Handshake and next-state for both stages; stalled stages keep their contents.
    always_comb begin
        s2_load_s   = !out_valid_q || out_ready;
        s1_load_s   = !s1_valid_q || s2_load_s;
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_ka_d     = s1_ka_q;
        s1_kb_d     = s1_kb_q;
        s1_zero_d   = s1_zero_q;
        out_valid_d = out_valid_q;
        log_a_d     = log_a_q;
        log_b_d     = log_b_q;
        zero_d      = zero_q;
        if (s1_load_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d    = a;
                s1_b_d    = b;
                s1_ka_d   = lead_one(a);
                s1_kb_d   = lead_one(b);
                s1_zero_d = (a == {IN_W{1'b0}}) || (b == {IN_W{1'b0}});
            end else begin
                s1_zero_d = s1_zero_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s2_load_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                log_a_d = pack_log(s1_a_q, s1_ka_q);
                log_b_d = pack_log(s1_b_q, s1_kb_q);
                zero_d  = s1_zero_q;
            end else begin
                zero_d  = zero_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= {IN_W{1'b0}};
            s1_b_q      <= {IN_W{1'b0}};
            s1_ka_q     <= {K_W{1'b0}};
            s1_kb_q     <= {K_W{1'b0}};
            s1_zero_q   <= 1'b0;
            out_valid_q <= 1'b0;
            log_a_q     <= {LOG_W{1'b0}};
            log_b_q     <= {LOG_W{1'b0}};
            zero_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_ka_q     <= s1_ka_d;
            s1_kb_q     <= s1_kb_d;
            s1_zero_q   <= s1_zero_d;
            out_valid_q <= out_valid_d;
            log_a_q     <= log_a_d;
            log_b_q     <= log_b_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = s1_load_s;
    assign out_valid = out_valid_q;
    assign log_a     = log_a_q;
    assign log_b     = log_b_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_mitchell_log_encoder.sv
// Self-checking bench for mitchell_log_encoder: directed vectors, back-pressure, full rate,
// random traffic against an arithmetic log model, and reset with pairs in flight.
module tb_mitchell_log_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] log_a, log_b;
    logic        zero;

    int errors = 0;
    int checks = 0;
    logic [22:0] exp_q[$];

    mitchell_log_encoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .log_a(log_a), .log_b(log_b), .zero(zero)
    );

    always #5 clk = ~clk;

    // Mitchell log from the definition: k = floor(log2 x), frac = floor((x/2^k - 1) * 2^7).
    function automatic logic [10:0] ref_log(input logic [15:0] x);
        int k;
        int frac;
        int xv;
        xv = int'(x);
        if (xv == 0) return 11'd0;
        k    = $clog2(xv + 1) - 1;
        frac = ((xv - (1 << k)) * 128) >> k;
`ifdef BIAS_COMP_EN
        frac = (frac + 5 > 127) ? 127 : frac + 5;
`endif
        return 11'(k * 128 + frac);
    endfunction

    function automatic logic [22:0] ref_pair(input logic [15:0] x, input logic [15:0] y);
        return {ref_log(x), ref_log(y), (x == 16'd0) || (y == 16'd0)};
    endfunction

    function automatic logic [15:0] rand_op();
        int sel;
        logic [15:0] v;
        sel = $urandom_range(0, 5);
        case (sel)
            0: v = 16'd0;
            1: v = 16'd1 << $urandom_range(0, 15);
            2: v = 16'hFFFF;
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    task automatic drive(input logic iv, input logic [15:0] av, input logic [15:0] bv, input logic orr);
        @(negedge clk);
        in_valid  = iv;
        a         = av;
        b         = bv;
        out_ready = orr;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; a = 16'd0; b = 16'd0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || log_a !== 11'd0 || log_b !== 11'd0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL reset: out_valid=%b in_ready=%b log_a=%h log_b=%h zero=%b, required 0 1 000 000 0",
                     out_valid, in_ready, log_a, log_b, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] va[3];
        logic [15:0] vb[3];
        logic [22:0] ve[3];
        va[0] = 16'h0001; vb[0] = 16'h8000;
        va[1] = 16'h00C0; vb[1] = 16'h0003;
        va[2] = 16'hFFFF; vb[2] = 16'h0000;
`ifdef BIAS_COMP_EN
        ve[0] = {11'h005, 11'h785, 1'b0};
        ve[1] = {11'h3C5, 11'h0C5, 1'b0};
`else
        ve[0] = {11'h000, 11'h780, 1'b0};
        ve[1] = {11'h3C0, 11'h0C0, 1'b0};
`endif
        ve[2] = {11'h7FF, 11'h000, 1'b1};
        for (int c = 0; c < 5; c++) begin
            if (c < 3) drive(1'b1, va[c], vb[c], 1'b1);
            else       drive(1'b0, 16'd0, 16'd0, 1'b1);
            if (c < 2) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL directed_latency cycle %0d: out_valid=%b required 0", c, out_valid);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b1 || {log_a, log_b, zero} !== ve[c-2]) begin
                    errors++;
                    $display("FAIL directed_T%0d: out_valid=%b log_a=%h log_b=%h zero=%b, required 1 %h %h %b",
                             c - 1, out_valid, log_a, log_b, zero, ve[c-2][22:12], ve[c-2][11:1], ve[c-2][0]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] pa[4];
        logic [15:0] pb[4];
        logic [22:0] held;
        logic        hold;
        logic [22:0] e;
        int idx = 0;
        int got = 0;
        hold = 1'b0;
        held = 23'd0;
        for (int i = 0; i < 4; i++) begin
            pa[i] = rand_op(); pb[i] = rand_op();
        end
        for (int c = 0; c < 40 && got < 4; c++) begin
            drive(idx < 4, (idx < 4) ? pa[idx] : 16'd0, (idx < 4) ? pb[idx] : 16'd0, c >= 5);
            if (c >= 2 && c <= 4) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_in_ready cycle %0d: in_ready=%b required 0", c, in_ready);
                end
            end
            if (c == 4) begin
                checks++;
                if (idx != 2) begin
                    errors++;
                    $display("FAIL bp_accepted: accepted=%0d required 2", idx);
                end
            end
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || {log_a, log_b, zero} !== held) begin
                    errors++;
                    $display("FAIL bp_hold cycle %0d: out_valid=%b data=%h required 1 %h", c, out_valid, {log_a, log_b, zero}, held);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_pair(pa[idx], pb[idx]));
                idx++;
            end
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                checks++;
                if ({log_a, log_b, zero} !== e) begin
                    errors++;
                    $display("FAIL bp_data #%0d: got %h %h %b required %h %h %b", got, log_a, log_b, zero, e[22:12], e[11:1], e[0]);
                end
                got++;
            end
            hold = out_valid && !out_ready;
            held = {log_a, log_b, zero};
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL bp_delivered: delivered=%0d required 4", got);
        end
        exp_q.delete();
    endtask

    task automatic test_full_rate();
        logic [15:0] pa[8];
        logic [15:0] pb[8];
        logic [22:0] e;
        int idx = 0;
        for (int i = 0; i < 8; i++) begin
            pa[i] = rand_op(); pb[i] = rand_op();
        end
        for (int c = 0; c < 12; c++) begin
            drive(c < 8, (c < 8) ? pa[c] : 16'd0, (c < 8) ? pb[c] : 16'd0, 1'b1);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_rate_in_ready cycle %0d: in_ready=%b required 1", c, in_ready);
            end
            checks++;
            if (out_valid !== (c >= 2 && c < 10)) begin
                errors++;
                $display("FAIL full_rate_valid cycle %0d: out_valid=%b required %b", c, out_valid, (c >= 2 && c < 10));
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_pair(pa[idx], pb[idx]));
                idx++;
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({log_a, log_b, zero} !== e) begin
                    errors++;
                    $display("FAIL full_rate_data cycle %0d: got %h %h %b required %h %h %b", c, log_a, log_b, zero, e[22:12], e[11:1], e[0]);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        logic [15:0] ra, rb;
        logic [22:0] held;
        logic        hold;
        logic [22:0] e;
        logic        iv, orr;
        int bad = 0;
        hold = 1'b0;
        held = 23'd0;
        for (int c = 0; c < 330; c++) begin
            iv  = (c < 300) && ($urandom_range(0, 3) != 0);
            orr = (c >= 300) || ($urandom_range(0, 2) != 0);
            ra  = rand_op();
            rb  = rand_op();
            drive(iv, ra, rb, orr);
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || {log_a, log_b, zero} !== held) begin
                    errors++;
                    $display("FAIL rand_hold cycle %0d: out_valid=%b data=%h required 1 %h", c, out_valid, {log_a, log_b, zero}, held);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_pair(ra, rb));
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra cycle %0d: output %h with empty model queue, required none", c, {log_a, log_b, zero});
                end else begin
                    e = exp_q.pop_front();
                    if ({log_a, log_b, zero} !== e) begin
                        errors++;
                        bad++;
                        if (bad < 10)
                            $display("FAIL rand_data cycle %0d: got %h %h %b required %h %h %b", c, log_a, log_b, zero, e[22:12], e[11:1], e[0]);
                    end
                end
            end
            hold = out_valid && !out_ready;
            held = {log_a, log_b, zero};
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: %0d pairs undelivered, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_midflight();
        logic [15:0] na, nb;
        logic [22:0] e;
        drive(1'b1, 16'h1234, 16'h0042, 1'b0);
        drive(1'b1, 16'h0007, 16'hABCD, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midflight_reset: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 16'd0, 16'd0, 1'b1);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midflight_ghost cycle %0d: out_valid=%b required 0", c, out_valid);
            end
        end
        na = rand_op();
        nb = rand_op();
        e  = ref_pair(na, nb);
        drive(1'b1, na, nb, 1'b1);
        drive(1'b0, 16'd0, 16'd0, 1'b1);
        drive(1'b0, 16'd0, 16'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || {log_a, log_b, zero} !== e) begin
            errors++;
            $display("FAIL midflight_new_pair: out_valid=%b got %h %h %b required 1 %h %h %b",
                     out_valid, log_a, log_b, zero, e[22:12], e[11:1], e[0]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_full_rate();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
